i2c_reg_bank: RTL and testbench
===============================

# i2c_reg_bank

Parametrised register bank behind the I2C slave's byte interface. It is the successor to the fixed eight-register interface. It adds:
- an internal auto-incrementing address pointer for multi-byte bursts;
- a per-register access mode (read/write, read-only hardware status, write-1-to-clear event);
- per-register write strobes and an interrupt output.

It sits between the I2C slave protocol engine and user logic.

## Interface
Parameters:
- NUM_REGS, 16, number of 8-bit registers (2..256)
- RO_MASK, 0, NUM_REGS bits; bit i=1 makes register i read-only, value taken from hwVal
- W1C_MASK, 0, NUM_REGS bits; bit i=1 makes register i an event register (hardware sets, bus write-1 clears); RO_MASK takes precedence
- RESET_VAL, 0, NUM_REGS*8 bits; reset value of register i at bits [8i+7:8i]

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- addr  in  8  register address byte from the slave engine
- ptrLoad  in  1  one-cycle pulse: load pointer from addr
- dataIn  in  8  write data byte
- writeEn  in  1  one-cycle pulse: write dataIn at pointer
- readAck  in  1  one-cycle pulse: master consumed dataOut, advance pointer
- dataOut  out  8  registered read data at pointer
- regsOut  out  NUM_REGS*8  flat view of all registers
- hwVal  in  NUM_REGS*8  live values for RO registers
- hwSet  in  NUM_REGS*8  per-bit set requests for W1C registers
- wrStrobe  out  NUM_REGS  one-cycle pulse per register written by the bus
- irq  out  1  OR of all W1C register bits

One clock; reset is asynchronous and active-high: `clk`, `rst`.

## Operation
- Pointer `ptr` is 8 bits.
  - ptrLoad: ptr <= addr.
  - Otherwise, writeEn or readAck: ptr <= (ptr >= NUM_REGS-1) ? 0 : ptr+1.
  - Wrap to 0 also applies to out-of-range pointers.
- Priority: ptrLoad beats writeEn/readAck; a coincident writeEn is dropped. writeEn+readAck together give one write and one increment.
- RW register: writeEn at ptr loads dataIn; wrStrobe[ptr] pulses the next cycle.
- RO register: each cycle reg <= hwVal slice. Bus writes are ignored, no wrStrobe, pointer still increments.
- W1C register: reg <= (reg & ~busClr) | hwSet.
  - busClr = dataIn on a write to that register, else 0.
  - Set wins over clear on the same bit in the same cycle.
  - wrStrobe pulses on a bus write.
- Out-of-range ptr (>= NUM_REGS): writes dropped, dataOut = 8'h00.
- dataOut <= reg[ptr] (0 if out of range) every cycle, including RO/W1C updates.
- irq <= |(all W1C register bits), registered.
- Reset values:
  - ptr = 0, dataOut = 0, wrStrobe = 0, irq = 0.
  - RW/W1C registers = RESET_VAL slice.
  - RO registers = 0 until the first clock after reset release.
- Reset mid-burst clears ptr and state immediately (async). The in-flight write is lost.

## Timing
- Edge N samples ptrLoad, giving new ptr after N. dataOut reflects the new register after edge N+1 (one-cycle latency).
- Edge N samples writeEn: register updated and ptr incremented after N; wrStrobe high for cycle N+1; dataOut shows the next register after N+1.
- Edge N applies hwSet: register bit set after N; irq high after N+1.
- Back-to-back writeEn on consecutive cycles is supported; each writes a successive register.

## Structure
- Package i2c_reg_pkg: access-mode constants REG_RW/REG_RO/REG_W1C and a function mode_of(i, RO_MASK, W1C_MASK).
- Sub-module i2c_reg_cell: one 8-bit register with mode parameter, write/clear/hwSet logic and strobe. Generate NUM_REGS instances.
- Top level holds the pointer, read mux, dataOut register and irq reduction.

## Test plan
- NUM_REGS=16, rst then release -> dataOut=00, irq=0, regsOut equals RESET_VAL, RO regs track hwVal one cycle later.
- ptrLoad addr=0x0E, writeEn 0xA1, 0xA2, 0xA3 -> reg14=A1, reg15=A2, reg0=A3; wrStrobe pulses bits 14, 15, 0 in order; ptr ends at 1.
- RO_MASK bit3, hwVal[3]=0x5C: ptrLoad 3, writeEn 0xFF -> reg3 stays 5C, no wrStrobe, ptr=4; readback after ptrLoad 3 gives dataOut=5C.
- W1C reg5=0x00: hwSet bit0 -> reg5=01, irq=1 next cycle. Bus write 0x01 with simultaneous hwSet bit0 -> reg5 stays 01. Write 0x01 alone -> reg5=00, irq=0.
- ptrLoad 0xF0 with NUM_REGS=16: dataOut=00, writeEn 0x77 changes nothing, ptr wraps to 0; ptrLoad+writeEn same cycle -> ptr=addr, no write.
- Assert rst mid-burst after two writes: ptr, dataOut, irq clear asynchronously; written RW registers return to RESET_VAL.

Source files
------------

// File: rtl/i2c_reg_pkg.sv
// Shared access-mode definitions for the I2C register bank and its cells.
package i2c_reg_pkg;

  typedef enum logic [1:0] {
    REG_RW  = 2'd0,
    REG_RO  = 2'd1,
    REG_W1C = 2'd2
  } reg_mode_e;

  localparam int MAX_REGS = 256;

  // Read-only wins when a register is flagged in both masks.
  function automatic reg_mode_e mode_of(input int i,
                                        input logic [MAX_REGS-1:0] ro_mask,
                                        input logic [MAX_REGS-1:0] w1c_mask);
    if (ro_mask[i[7:0]]) return REG_RO;
    if (w1c_mask[i[7:0]]) return REG_W1C;
    return REG_RW;
  endfunction

endpackage

// File: rtl/i2c_reg_cell.sv
// One 8-bit register of the bank: read/write, hardware-tracked read-only,
// or write-1-to-clear event register, plus its bus write strobe.
module i2c_reg_cell
  import i2c_reg_pkg::*;
#(
  parameter reg_mode_e  MODE      = REG_RW,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] data,
  input  logic [7:0] hw_val,
  input  logic [7:0] hw_set,
  output logic [7:0] value,
  output logic       strobe
);

  // Hardware set is OR-ed in after the bus clear so it wins on a shared bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value  <= (MODE == REG_RO) ? 8'h00 : RESET_VAL;
      strobe <= 1'b0;
    end else begin
      strobe <= wr && (MODE != REG_RO);
      case (MODE)
        REG_RO:  value <= hw_val;
        REG_W1C: value <= (value & ~(wr ? data : 8'h00)) | hw_set;
        default: if (wr) value <= data;
      endcase
    end
  end

endmodule

// File: rtl/i2c_reg_bank.sv
// Register bank behind the I2C slave byte interface: auto-incrementing
// pointer, registered read data, per-register strobes and event interrupt.
module i2c_reg_bank
  import i2c_reg_pkg::*;
#(
  parameter int                    NUM_REGS  = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK   = '0,
  parameter logic [NUM_REGS-1:0]   W1C_MASK  = '0,
  parameter logic [NUM_REGS*8-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            addr,
  input  logic                  ptrLoad,
  input  logic [7:0]            dataIn,
  input  logic                  writeEn,
  input  logic                  readAck,
  output logic [7:0]            dataOut,
  output logic [NUM_REGS*8-1:0] regsOut,
  input  logic [NUM_REGS*8-1:0] hwVal,
  input  logic [NUM_REGS*8-1:0] hwSet,
  output logic [NUM_REGS-1:0]   wrStrobe,
  output logic                  irq
);

  localparam int                  IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0]          LAST_IDX = 8'(NUM_REGS - 1);
  localparam logic [MAX_REGS-1:0] RO_EXT   = MAX_REGS'(RO_MASK);
  localparam logic [MAX_REGS-1:0] W1C_EXT  = MAX_REGS'(W1C_MASK);

  logic [7:0]          ptr;
  logic [7:0]          regs [NUM_REGS];
  logic [NUM_REGS-1:0] w1c_bits;
  logic                write_go;
  logic                in_range;

  // A pointer load in the same cycle swallows the write.
  assign write_go = writeEn && !ptrLoad;
  assign in_range = {1'b0, ptr} < 9'(NUM_REGS);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam reg_mode_e MODE = mode_of(i, RO_EXT, W1C_EXT);

    i2c_reg_cell #(
      .MODE      (MODE),
      .RESET_VAL (RESET_VAL[8*i +: 8])
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .wr     (write_go && (ptr == 8'(i))),
      .data   (dataIn),
      .hw_val (hwVal[8*i +: 8]),
      .hw_set (hwSet[8*i +: 8]),
      .value  (regs[i]),
      .strobe (wrStrobe[i])
    );

    assign regsOut[8*i +: 8] = regs[i];
    assign w1c_bits[i]       = (MODE == REG_W1C) && (|regs[i]);
  end

  // Out-of-range pointers also wrap to zero on the next increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= 8'h00;
      dataOut <= 8'h00;
      irq     <= 1'b0;
    end else begin
      if (ptrLoad)
        ptr <= addr;
      else if (writeEn || readAck)
        ptr <= (ptr >= LAST_IDX) ? 8'h00 : ptr + 8'd1;
      dataOut <= in_range ? regs[ptr[IDX_W-1:0]] : 8'h00;
      irq     <= |w1c_bits;
    end
  end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Self-checking bench for i2c_reg_bank: table of per-cycle vectors fed
// through an expectation queue, plus reset sequences.
module tb_i2c_reg_bank;

  localparam int          N   = 16;
  localparam logic [15:0] RO  = 16'h0008;
  localparam logic [15:0] W1C = 16'h0020;

  function automatic logic [127:0] reset_image(input bit ro_zero);
    logic [127:0] img;
    img = '0;
    for (int i = 0; i < N; i++) begin
      logic [7:0] v;
      v = 8'(8'h40 + i);
      if (i == 5) v = 8'h00;
      if (i == 3 && ro_zero) v = 8'h00;
      img[i*8 +: 8] = v;
    end
    return img;
  endfunction

  localparam logic [127:0] RV = reset_image(1'b0);

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   addr;
  logic         ptrLoad;
  logic [7:0]   dataIn;
  logic         writeEn;
  logic         readAck;
  logic [7:0]   dataOut;
  logic [127:0] regsOut;
  logic [127:0] hwVal;
  logic [127:0] hwSet;
  logic [15:0]  wrStrobe;
  logic         irq;

  int checks   = 0;
  int failures = 0;

  i2c_reg_bank #(
    .NUM_REGS  (N),
    .RO_MASK   (RO),
    .W1C_MASK  (W1C),
    .RESET_VAL (RV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .ptrLoad  (ptrLoad),
    .dataIn   (dataIn),
    .writeEn  (writeEn),
    .readAck  (readAck),
    .dataOut  (dataOut),
    .regsOut  (regsOut),
    .hwVal    (hwVal),
    .hwSet    (hwSet),
    .wrStrobe (wrStrobe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pl;
    logic [7:0]  addr;
    logic        we;
    logic [7:0]  din;
    logic        ra;
    logic [7:0]  hs5;
    logic [7:0]  hw3;
    logic [7:0]  dout;
    logic [15:0] strobe;
    int          irq;
    int          reg_idx;
    logic [7:0]  reg_val;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic pl, input logic [7:0] a, input logic we,
                              input logic [7:0] d, input logic ra, input logic [7:0] hs5,
                              input logic [7:0] hw3, input logic [7:0] dout,
                              input logic [15:0] strobe, input int irq_exp,
                              input int ridx, input logic [7:0] rval);
    vec_t r;
    r.pl = pl; r.addr = a; r.we = we; r.din = d; r.ra = ra; r.hs5 = hs5; r.hw3 = hw3;
    r.dout = dout; r.strobe = strobe; r.irq = irq_exp; r.reg_idx = ridx; r.reg_val = rval;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_hw(input logic [7:0] hw3, input logic [7:0] hs5);
    logic [127:0] hv;
    hv = {16{8'hEE}};
    hv[31:24] = hw3;
    hwVal = hv;
    hwSet = 128'(hs5) << 40;
  endtask

  task automatic applyStimulus(input vec_t r);
    ptrLoad = r.pl;
    addr    = r.addr;
    writeEn = r.we;
    dataIn  = r.din;
    readAck = r.ra;
    drive_hw(r.hw3, r.hs5);
    exp_q.push_back(r);
    @(posedge clk);
    #1;
    ptrLoad = 1'b0;
    writeEn = 1'b0;
    readAck = 1'b0;
    hwSet   = '0;
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, " queue"}, 128'd0, 128'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, " dataOut"}, 128'(dataOut), 128'(e.dout));
    check({tag, " wrStrobe"}, 128'(wrStrobe), 128'(e.strobe));
    if (e.irq >= 0) check({tag, " irq"}, 128'(irq), 128'(e.irq));
    if (e.reg_idx >= 0)
      check($sformatf("%s reg%0d", tag, e.reg_idx), 128'(regsOut[e.reg_idx*8 +: 8]), 128'(e.reg_val));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] img;

    rst = 1'b1; addr = '0; ptrLoad = 0; dataIn = '0; writeEn = 0; readAck = 0;
    drive_hw(8'h5C, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset dataOut", 128'(dataOut), 128'h0);
    check("reset irq", 128'(irq), 128'h0);
    check("reset wrStrobe", 128'(wrStrobe), 128'h0);
    check("reset regsOut", regsOut, reset_image(1'b1));
    rst = 1'b0;

    // pl, addr, we, din, ra, hs5, hw3, dout, strobe, irq, reg_idx, reg_val
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h40, 16'h0000,  0,  3, 8'h5C));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h33, 8'h40, 16'h0000, -1,  3, 8'h33));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h40, 16'h0000, -1,  3, 8'h5C));
    vecs.push_back(mk(1, 8'h0E, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h40, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h00, 1, 8'hA1, 0, 8'h00, 8'h5C, 8'h4E, 16'h4000, -1, 14, 8'hA1));
    vecs.push_back(mk(0, 8'h00, 1, 8'hA2, 0, 8'h00, 8'h5C, 8'h4F, 16'h8000, -1, 15, 8'hA2));
    vecs.push_back(mk(0, 8'h00, 1, 8'hA3, 0, 8'h00, 8'h5C, 8'h40, 16'h0001, -1,  0, 8'hA3));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h41, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(1, 8'h0E, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h41, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h5C, 8'hA1, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 8'h00, 8'h5C, 8'hA1, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, 8'h00, 8'h5C, 8'hA2, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h5C, 8'hA3, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(1, 8'h03, 0, 8'h00, 0, 8'h00, 8'h5C, 8'hA3, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h00, 1, 8'hFF, 0, 8'h00, 8'h5C, 8'h5C, 16'h0000, -1,  3, 8'h5C));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h44, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(1, 8'h03, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h44, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h5C, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(1, 8'hF0, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h5C, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h00, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h00, 1, 8'h77, 0, 8'h00, 8'h5C, 8'h00, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h5C, 8'hA3, 16'h0000, -1,  0, 8'hA3));
    vecs.push_back(mk(1, 8'h02, 1, 8'h99, 0, 8'h00, 8'h5C, 8'hA3, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h42, 16'h0000, -1,  2, 8'h42));
    vecs.push_back(mk(1, 8'h00, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h42, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h5C, 8'hA3, 16'h0000, -1,  0, 8'hA3));
    vecs.push_back(mk(1, 8'h06, 0, 8'h00, 0, 8'h00, 8'h5C, 8'hA3, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h00, 1, 8'h66, 1, 8'h00, 8'h5C, 8'h46, 16'h0040, -1,  6, 8'h66));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h47, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(1, 8'h06, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h47, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h66, 16'h0000, -1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 8'h01, 8'h5C, 8'h66, 16'h0000,  0,  5, 8'h01));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h66, 16'h0000,  1,  5, 8'h01));
    vecs.push_back(mk(1, 8'h05, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h66, 16'h0000,  1, -1, 8'h00));
    vecs.push_back(mk(0, 8'h00, 1, 8'h01, 0, 8'h01, 8'h5C, 8'h01, 16'h0020,  1,  5, 8'h01));
    vecs.push_back(mk(1, 8'h05, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h66, 16'h0000,  1,  5, 8'h01));
    vecs.push_back(mk(0, 8'h00, 1, 8'h01, 0, 8'h00, 8'h5C, 8'h01, 16'h0020,  1,  5, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h66, 16'h0000,  0,  5, 8'h00));
    vecs.push_back(mk(1, 8'h08, 0, 8'h00, 0, 8'h01, 8'h5C, 8'h66, 16'h0000,  0,  5, 8'h01));
    vecs.push_back(mk(0, 8'h00, 1, 8'hB1, 0, 8'h00, 8'h5C, 8'h48, 16'h0100,  1,  8, 8'hB1));
    vecs.push_back(mk(0, 8'h00, 1, 8'hB2, 0, 8'h00, 8'h5C, 8'h49, 16'h0200,  1,  9, 8'hB2));

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k]);
      checkOutput($sformatf("step%0d", k));
    end

    img = reset_image(1'b1);
    img[7:0]     = 8'hA3;
    img[31:24]   = 8'h5C;
    img[47:40]   = 8'h01;
    img[55:48]   = 8'h66;
    img[71:64]   = 8'hB1;
    img[79:72]   = 8'hB2;
    img[119:112] = 8'hA1;
    img[127:120] = 8'hA2;
    check("burst regsOut", regsOut, img);

    // Reset lands mid-cycle while a third write is pending.
    writeEn = 1'b1;
    dataIn  = 8'hC3;
    #2 rst = 1'b1;
    #1;
    check("midrst dataOut", 128'(dataOut), 128'h0);
    check("midrst irq", 128'(irq), 128'h0);
    check("midrst wrStrobe", 128'(wrStrobe), 128'h0);
    check("midrst regsOut", regsOut, reset_image(1'b1));
    @(negedge clk);
    writeEn = 1'b0;
    check("midrst held reg10", 128'(regsOut[87:80]), 128'h4A);
    rst = 1'b0;
    applyStimulus(mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h5C, 8'h40, 16'h0000, 0, 3, 8'h5C));
    checkOutput("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
